bram_dp_param: RTL and testbench
================================

BRAM_DP_PARAM -- requirements
Module: bram_dp_param

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits (signed data stored as raw bits).
REQ-002 Parameter ADDR_W, default 10, address width; depth DEPTH = 2**ADDR_W words.
REQ-003 Parameter RD_LAT, default 1, read latency in cycles; legal values 1 or 2.
REQ-004 Parameter WRITE_FIRST, default 0, same-port read-during-write: 0 returns old data, 1 returns new data.
REQ-005 Parameter CLR_ON_RESET, default 1, when 1 a full memory clear sweep runs automatically after reset.
REQ-006 clk  in  1  clock; all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 a_en / b_en  in  1  port access request, per port.
REQ-009 a_we / b_we  in  1  write enable, qualified by x_en.
REQ-010 a_addr / b_addr  in  ADDR_W  word address.
REQ-011 a_wdata / b_wdata  in  DATA_W  write data.
REQ-012 a_rdata / b_rdata  out  DATA_W  read data.
REQ-013 a_rvalid / b_rvalid  out  1  marks x_rdata valid for exactly one cycle.
REQ-014 clr_start  in  1  single-cycle request for a full memory clear.
REQ-015 clr_busy  out  1  clear sweep in progress; port accesses ignored.
REQ-016 collision  out  1  same-address write conflict flag (present only under DP_COLLISION_EN).

Function
REQ-017 Accepted access: x_en=1 and clr_busy=0 in the same cycle; otherwise the request is dropped, with no write and no rvalid.
REQ-018 An accepted read (x_we=0) or write (x_we=1) produces x_rvalid=1 and x_rdata exactly RD_LAT cycles later.
REQ-019 Write rdata: old word when WRITE_FIRST=0, written word when WRITE_FIRST=1.
REQ-020 Cross-port read of an address written by the other port in the same cycle returns the old word.
REQ-021 Both ports write the same address in the same cycle: port A data is stored; port B write is discarded.
REQ-022 RD_LAT=2 adds one output register stage; rvalid is pipelined alongside it; throughput is one access per port per cycle.
REQ-023 x_rdata holds its last value while x_rvalid=0.
REQ-024 Clear FSM has two states, IDLE and CLEAR.
REQ-025 IDLE->CLEAR on clr_start=1, or on the first cycle after rst deasserts when CLR_ON_RESET=1.
REQ-026 In CLEAR, one word per cycle is written to zero, from address 0 up to DEPTH-1; the sweep takes DEPTH cycles.
REQ-027 CLEAR->IDLE after address DEPTH-1 is written; clr_busy=1 exactly during CLEAR.
REQ-028 clr_start while in CLEAR is ignored and does not restart the sweep.
REQ-029 In-flight reads accepted before clr_busy rose complete normally with pre-clear data.
REQ-030 The clear address counter wraps nothing; it stops at DEPTH-1.

Reset
REQ-031 While rst=1: a_rdata=b_rdata=0, a_rvalid=b_rvalid=0, clr_busy=0, collision=0, FSM=IDLE, read pipelines flushed.
REQ-032 Memory contents are not altered by rst itself.
REQ-033 rst asserted mid-sweep aborts it; with CLR_ON_RESET=1 the sweep restarts from address 0 after rst deasserts.

Configuration
REQ-034 Macro DP_COLLISION_EN defined: collision registers 1 for one cycle, one cycle after both ports are accepted with the same address and at least one writes.
REQ-035 Macro DP_COLLISION_EN undefined: the collision port and its logic are absent; all other behaviour is identical.

Structure
REQ-036 Shared package bram_pkg holds clear-FSM state typedef (IDLE, CLEAR) and default width/depth constants.
REQ-037 One sub-module, bram_rd_pipe, implements the RD_LAT data/valid delay; it is instantiated once per port.

Verification
REQ-038 Reset with CLR_ON_RESET=1, ADDR_W=10 -> clr_busy high for 1024 cycles, then all reads return 0x00.
REQ-039 A writes 0x5A @0x010, then A reads 0x010 with RD_LAT=2 -> a_rvalid 2 cycles later, a_rdata=0x5A.
REQ-040 Same cycle: A writes 0x11 @0x020, B writes 0x22 @0x020 -> later read returns 0x11; collision pulses (macro on).
REQ-041 Pre-load 0x33 @0x030; A writes 0x44 @0x030 with WRITE_FIRST=0 -> a_rdata=0x33; with WRITE_FIRST=1 -> a_rdata=0x44.
REQ-042 clr_start, then rst at sweep cycle 300 -> sweep restarts at 0 and ends 1024 cycles after rst release; accesses during busy are dropped, with no rvalid.
REQ-043 B reads 0x3FF while A writes 0x7F @0x3FF -> b_rdata returns the old word; the next read returns 0x7F.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared types and default sizing for the parameterised dual-port block RAM.
package bram_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 10;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;
endpackage

// File: rtl/bram_rd_pipe.sv
// Read data/valid delay line: RD_LAT registered stages, data held while valid is low.
module bram_rd_pipe #(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o
);
  logic [RD_LAT:1]             vld_pipe_q;
  logic [RD_LAT:1][DATA_W-1:0] dat_pipe_q;

  // Each stage only loads when a valid word arrives, so the output holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
    end else begin
      vld_pipe_q[1] <= vld_i;
      if (vld_i) dat_pipe_q[1] <= data_i;
      for (int s = 2; s <= RD_LAT; s++) begin
        vld_pipe_q[s] <= vld_pipe_q[s-1];
        if (vld_pipe_q[s-1]) dat_pipe_q[s] <= dat_pipe_q[s-1];
      end
    end
  end

  assign vld_o  = vld_pipe_q[RD_LAT];
  assign data_o = dat_pipe_q[RD_LAT];
endmodule

// File: rtl/bram_dp_param.sv
// True dual-port RAM with selectable read latency, read-during-write mode and clear sweep.
// Optional same-address conflict flag enabled by defining DP_COLLISION_EN.
module bram_dp_param
  import bram_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int RD_LAT       = 1,
  parameter int WRITE_FIRST  = 0,
  parameter int CLR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  input  logic              clr_start,
  output logic              clr_busy
`ifdef DP_COLLISION_EN
  ,output logic             collision
`endif
);
  localparam int                DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  logic [DATA_W-1:0] mem [DEPTH];

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              rst_pend_q;

  logic              a_acc, b_acc, a_wr, b_wr;
  logic [DATA_W-1:0] a_word, b_word;

  assign clr_busy = (state_q == CLEAR);
  assign a_acc    = a_en & ~clr_busy & ~rst;
  assign b_acc    = b_en & ~clr_busy & ~rst;
  assign a_wr     = a_acc & a_we;
  // Port A owns the address when both ports write it in the same cycle.
  assign b_wr     = b_acc & b_we & ~(a_wr && (a_addr == b_addr));

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_busy) begin
        mem[clr_addr_q] <= '0;
      end else begin
        if (b_wr) mem[b_addr] <= b_wdata;
        if (a_wr) mem[a_addr] <= a_wdata;
      end
    end
  end

  // Array reads see pre-edge contents, giving old data across ports and in read-first mode.
  assign a_word = (WRITE_FIRST != 0 && a_we) ? a_wdata : mem[a_addr];
  assign b_word = (WRITE_FIRST != 0 && b_we) ? b_wdata : mem[b_addr];

  bram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_rd_a (
    .clk    (clk),
    .rst    (rst),
    .vld_i  (a_acc),
    .data_i (a_word),
    .vld_o  (a_rvalid),
    .data_o (a_rdata)
  );

  bram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_rd_b (
    .clk    (clk),
    .rst    (rst),
    .vld_i  (b_acc),
    .data_i (b_word),
    .vld_o  (b_rvalid),
    .data_o (b_rdata)
  );

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      IDLE: begin
        // rst_pend_q is high only on the first cycle after reset is released.
        if (clr_start || (CLR_ON_RESET != 0 && rst_pend_q)) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
      CLEAR: begin
        if (clr_addr_q == ADDR_LAST) state_d = IDLE;
        else                         clr_addr_d = clr_addr_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      clr_addr_q <= '0;
      rst_pend_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      rst_pend_q <= 1'b0;
    end
  end

`ifdef DP_COLLISION_EN
  logic collision_q;
  always_ff @(posedge clk) begin
    if (rst) collision_q <= 1'b0;
    else     collision_q <= a_acc & b_acc & (a_addr == b_addr) & (a_we | b_we);
  end
  assign collision = collision_q;
`endif
endmodule

// File: tb/tb_bram_dp_param.sv
// Directed bench: two instances (RD_LAT=2 read-first, RD_LAT=1 write-first) share stimulus.
module tb_bram_dp_param;
  logic       clk = 1'b0;
  logic       rst;
  logic       a_en, a_we, b_en, b_we, clr_start;
  logic [9:0] a_addr, b_addr;
  logic [7:0] a_wd, b_wd;
  logic [7:0] a_rd2, b_rd2, a_rd1, b_rd1;
  logic       a_rv2, b_rv2, a_rv1, b_rv1, busy2, busy1;
`ifdef DP_COLLISION_EN
  logic       coll2, coll1;
`endif

  int checks = 0;
  int errors = 0;
  int n2, n1;

  always #5 clk = ~clk;

  bram_dp_param #(.DATA_W(8), .ADDR_W(10), .RD_LAT(2), .WRITE_FIRST(0), .CLR_ON_RESET(1)) dut2 (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wd), .a_rdata(a_rd2), .a_rvalid(a_rv2),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wd), .b_rdata(b_rd2), .b_rvalid(b_rv2),
    .clr_start(clr_start), .clr_busy(busy2)
`ifdef DP_COLLISION_EN
    ,.collision(coll2)
`endif
  );

  bram_dp_param #(.DATA_W(8), .ADDR_W(10), .RD_LAT(1), .WRITE_FIRST(1), .CLR_ON_RESET(1)) dut1 (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wd), .a_rdata(a_rd1), .a_rvalid(a_rv1),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wd), .b_rdata(b_rd1), .b_rvalid(b_rv1),
    .clr_start(clr_start), .clr_busy(busy1)
`ifdef DP_COLLISION_EN
    ,.collision(coll1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of port requests from a negedge; returns at the next negedge.
  task automatic acc(input logic ae, input logic awe, input logic [9:0] aa, input logic [7:0] ad,
                     input logic be, input logic bwe, input logic [9:0] ba, input logic [7:0] bd);
    a_en = ae; a_we = awe; a_addr = aa; a_wd = ad;
    b_en = be; b_we = bwe; b_addr = ba; b_wd = bd;
    @(negedge clk);
    a_en = 1'b0; a_we = 1'b0; b_en = 1'b0; b_we = 1'b0; clr_start = 1'b0;
  endtask

  // Count busy cycles of both instances; optionally pulse clr_start mid-sweep.
  task automatic busy_len(input int pulse_at, output int c2, output int c1);
    c2 = 0; c1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if (busy2) c2++;
      if (busy1) c1++;
      clr_start = (c2 == pulse_at);
      if (!busy2 && !busy1 && c2 > 0) break;
      @(negedge clk);
    end
    clr_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr_start = 1'b0;
    a_en = 0; a_we = 0; a_addr = '0; a_wd = '0;
    b_en = 0; b_we = 0; b_addr = '0; b_wd = '0;
    repeat (3) @(negedge clk);
    chk("rst_a_rdata", a_rd2, 0);
    chk("rst_a_rvalid", a_rv2, 0);
    chk("rst_b_rvalid", b_rv1, 0);
    chk("rst_busy2", busy2, 0);
    chk("rst_busy1", busy1, 0);
`ifdef DP_COLLISION_EN
    chk("rst_coll", coll2, 0);
`endif
    rst = 1'b0;
    busy_len(-1, n2, n1);
    chk("por_sweep_len2", n2, 1024);
    chk("por_sweep_len1", n1, 1024);

    // Cleared memory reads back as zero at both ends of the array
    acc(1, 0, 10'h000, 0, 1, 0, 10'h3FF, 0);
    chk("clr_rd_a_v1", a_rv1, 1);
    chk("clr_rd_a_d1", a_rd1, 0);
    chk("clr_rd_b_d1", b_rd1, 0);
    @(negedge clk);
    chk("clr_rd_a_v2", a_rv2, 1);
    chk("clr_rd_b_v2", b_rv2, 1);
    chk("clr_rd_b_d2", b_rd2, 0);

    // Write 0x5A @0x010, then read it back with both latencies
    acc(1, 1, 10'h010, 8'h5A, 0, 0, 0, 0);
    chk("wr5a_wf1_data", a_rd1, 8'h5A);
    chk("wr5a_wf1_vld", a_rv1, 1);
    @(negedge clk);
    chk("wr5a_rf_vld", a_rv2, 1);
    chk("wr5a_rf_old", a_rd2, 8'h00);
    acc(1, 0, 10'h010, 0, 0, 0, 0, 0);
    chk("rd5a_lat2_early", a_rv2, 0);
    chk("rd5a_lat1", a_rd1, 8'h5A);
    @(negedge clk);
    chk("rd5a_lat2_vld", a_rv2, 1);
    chk("rd5a_lat2_data", a_rd2, 8'h5A);
    @(negedge clk);
    chk("rd5a_vld_drop", a_rv2, 0);
    chk("rd5a_hold", a_rd2, 8'h5A);
    chk("rd5a_vld1_drop", a_rv1, 0);

    // Same-address write from both ports: A wins
    acc(1, 1, 10'h020, 8'h11, 1, 1, 10'h020, 8'h22);
    chk("coll_b_wf1", b_rd1, 8'h22);
`ifdef DP_COLLISION_EN
    chk("coll_pulse", coll1, 1);
`endif
    @(negedge clk);
`ifdef DP_COLLISION_EN
    chk("coll_one_cycle", coll1, 0);
    chk("coll_pulse_lat2", coll2, 0);
`endif
    acc(0, 0, 0, 0, 1, 0, 10'h020, 0);
    chk("coll_rd1", b_rd1, 8'h11);
    @(negedge clk);
    chk("coll_rd2", b_rd2, 8'h11);

    // Read-during-write on the same port
    acc(1, 1, 10'h030, 8'h33, 0, 0, 0, 0);
    @(negedge clk);
    acc(1, 1, 10'h030, 8'h44, 0, 0, 0, 0);
    chk("rdw_wf1", a_rd1, 8'h44);
    @(negedge clk);
    chk("rdw_wf0", a_rd2, 8'h33);

    // Cross-port read of the top address while A writes it
    acc(1, 1, 10'h3FF, 8'h7F, 1, 0, 10'h3FF, 0);
    chk("xport_old1", b_rd1, 8'h00);
    @(negedge clk);
    chk("xport_old2", b_rd2, 8'h00);
    acc(0, 0, 0, 0, 1, 0, 10'h3FF, 0);
    chk("xport_new1", b_rd1, 8'h7F);
    @(negedge clk);
    chk("xport_new2", b_rd2, 8'h7F);

    // Write with en low is dropped
    acc(0, 1, 10'h040, 8'h66, 0, 0, 0, 0);
    chk("noen_vld", a_rv1, 0);
    acc(1, 0, 10'h040, 0, 0, 0, 0, 0);
    chk("noen_data", a_rd1, 8'h00);

    // Read accepted alongside clr_start completes with pre-clear data
    @(negedge clk);
    clr_start = 1'b1;
    acc(1, 0, 10'h030, 0, 0, 0, 0, 0);
    chk("inflight_v1", a_rv1, 1);
    chk("inflight_d1", a_rd1, 8'h44);
    chk("busy_rise", busy2, 1);
    @(negedge clk);
    chk("inflight_v2", a_rv2, 1);
    chk("inflight_d2", a_rd2, 8'h44);

    // Accesses during the sweep are ignored
    repeat (3) @(negedge clk);
    acc(1, 0, 10'h010, 0, 1, 1, 10'h020, 8'h99);
    chk("busy_drop_a1", a_rv1, 0);
    chk("busy_drop_b1", b_rv1, 0);
    @(negedge clk);
    chk("busy_drop_a2", a_rv2, 0);
    chk("busy_drop_b2", b_rv2, 0);

    // Reset mid-sweep aborts it; the sweep restarts and a stray clr_start is ignored
    repeat (290) @(negedge clk);
    chk("midsweep_busy", busy2, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_busy", busy2, 0);
    chk("abort_rvalid", a_rv2, 0);
    chk("abort_rdata", a_rd2, 0);
    rst = 1'b0;
    busy_len(500, n2, n1);
    chk("restart_len2", n2, 1024);
    chk("restart_len1", n1, 1024);

    acc(1, 0, 10'h010, 0, 1, 0, 10'h3FF, 0);
    chk("post_clr_a1", a_rd1, 8'h00);
    chk("post_clr_b1", b_rd1, 8'h00);
    @(negedge clk);
    chk("post_clr_a2", a_rd2, 8'h00);
    chk("post_clr_b2", b_rd2, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
